// File: rtl/flush_redirect_if.sv
// Flush/redirect bundle: flush request in, redirect/kill pulses and ROB/RAT rollback handshakes out.
// master = the environment (flush controller, ROB, RAT, fetch); slave = flush_redirect_unit.
// Signals: must_flush/correct_address/rob_ticket/rat_id/rob_head/readys in; redirect, kills, valids, stall, busy out.
interface flush_redirect_if #(
    parameter int ADDR_W   = 32,
    parameter int TICKET_W = 3
);
    logic                must_flush;
    logic [ADDR_W-1:0]   correct_address;
    logic [TICKET_W-1:0] rob_ticket;
    logic                rat_id;
    logic [TICKET_W-1:0] rob_head;
    logic                rob_rollback_ready;
    logic                rat_restore_ready;

    logic                fetch_redirect_valid;
    logic [ADDR_W-1:0]   fetch_redirect_pc;
    logic                flush_frontend;
    logic                flush_backend;
    logic [TICKET_W-1:0] flush_ticket;
    logic                rob_rollback_valid;
    logic                rat_restore_valid;
    logic                rat_restore_id;
    logic                frontend_stall;
    logic                busy;

    modport master (
        output must_flush, correct_address, rob_ticket, rat_id, rob_head,
               rob_rollback_ready, rat_restore_ready,
        input  fetch_redirect_valid, fetch_redirect_pc, flush_frontend, flush_backend,
               flush_ticket, rob_rollback_valid, rat_restore_valid, rat_restore_id,
               frontend_stall, busy
    );

    modport slave (
        input  must_flush, correct_address, rob_ticket, rat_id, rob_head,
               rob_rollback_ready, rat_restore_ready,
        output fetch_redirect_valid, fetch_redirect_pc, flush_frontend, flush_backend,
               flush_ticket, rob_rollback_valid, rat_restore_valid, rat_restore_id,
               frontend_stall, busy
    );
endinterface

// File: rtl/flush_redirect_unit.sv
// Purpose: registers flushes, pulses fetch redirect + front/back-end kills, runs ROB/RAT rollback handshakes, drains, releases fetch.
// Latency: pulses and valids one cycle after must_flush; IDLE DRAIN_CYCLES cycles after both handshakes complete.
// Backpressure: rollback/restore valids held until their ready; an older flush (by ROB age) overrides any activity.
// Ports: clk, rst_n (async active-low), fr (flush_redirect_if.slave) carrying all request/response signals.
module flush_redirect_unit #(
    parameter int ADDR_W       = 32,
    parameter int TICKET_W     = 3,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    flush_redirect_if.slave   fr
);
    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROLLBACK = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [TICKET_W-1:0] ticket_q, ticket_d;
    logic                rid_q, rid_d;
    logic                pulse_q, pulse_d;
    logic                rob_vld_q, rob_vld_d;
    logic                rat_vld_q, rat_vld_d;
    logic                rob_done_q, rob_done_d;
    logic                rat_done_q, rat_done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Ages relative to the current ROB head; modular subtraction handles wrap-around.
    logic [TICKET_W-1:0] age_new, age_cur;
    logic                accept;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ticket_d   = ticket_q;
        rid_d      = rid_q;
        pulse_d    = 1'b0;
        rob_vld_d  = rob_vld_q;
        rat_vld_d  = rat_vld_q;
        rob_done_d = rob_done_q;
        rat_done_d = rat_done_q;
        cnt_d      = cnt_q;

        age_new = fr.rob_ticket - fr.rob_head;
        age_cur = ticket_q - fr.rob_head;
        // While busy only a strictly older branch matters; younger/same ones are already killed.
        accept  = fr.must_flush && ((state_q == IDLE) || (age_new < age_cur));

        case (state_q)
            IDLE: begin
            end
            ROLLBACK: begin
                if (rob_vld_q && fr.rob_rollback_ready) begin
                    rob_vld_d  = 1'b0;
                    rob_done_d = 1'b1;
                end
                if (rat_vld_q && fr.rat_restore_ready) begin
                    rat_vld_d  = 1'b0;
                    rat_done_d = 1'b1;
                end
                if (rob_done_d && rat_done_d) begin
                    rob_done_d = 1'b0;
                    rat_done_d = 1'b0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(DRAIN_CYCLES);
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Applied last so a new/older flush beats handshake completion and drain expiry.
        if (accept) begin
            state_d    = ROLLBACK;
            pc_d       = fr.correct_address;
            ticket_d   = fr.rob_ticket;
            rid_d      = fr.rat_id;
            pulse_d    = 1'b1;
            rob_vld_d  = 1'b1;
            rat_vld_d  = 1'b1;
            rob_done_d = 1'b0;
            rat_done_d = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ticket_q   <= '0;
            rid_q      <= 1'b0;
            pulse_q    <= 1'b0;
            rob_vld_q  <= 1'b0;
            rat_vld_q  <= 1'b0;
            rob_done_q <= 1'b0;
            rat_done_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ticket_q   <= ticket_d;
            rid_q      <= rid_d;
            pulse_q    <= pulse_d;
            rob_vld_q  <= rob_vld_d;
            rat_vld_q  <= rat_vld_d;
            rob_done_q <= rob_done_d;
            rat_done_q <= rat_done_d;
            cnt_q      <= cnt_d;
        end
    end

    // One pulse register drives redirect and both kills so they can never disagree.
    assign fr.fetch_redirect_valid = pulse_q;
    assign fr.flush_frontend       = pulse_q;
    assign fr.flush_backend        = pulse_q;
    assign fr.fetch_redirect_pc    = pc_q;
    assign fr.flush_ticket         = ticket_q;
    assign fr.rat_restore_id       = rid_q;
    assign fr.rob_rollback_valid   = rob_vld_q;
    assign fr.rat_restore_valid    = rat_vld_q;
    assign fr.busy                 = (state_q != IDLE);
    assign fr.frontend_stall       = (state_q != IDLE);
endmodule

// File: tb/tb_flush_redirect_unit.sv
// Bench for flush_redirect_unit: directed scenarios then random traffic, all checked against a cycle reference model.
// Inputs driven at the falling edge, outputs compared at the following falling edge.
module tb_flush_redirect_unit;
    localparam int AW    = 32;
    localparam int TW    = 3;
    localparam int DEPTH = 1 << TW;
    localparam int DRAIN = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    flush_redirect_if #(.ADDR_W(AW), .TICKET_W(TW)) fr ();

    flush_redirect_unit #(.ADDR_W(AW), .TICKET_W(TW), .DRAIN_CYCLES(DRAIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fr    (fr)
    );

    // Reference model: "busy" plus outstanding-handshake flags and a remaining-drain count.
    bit          m_busy, m_rob, m_rat, m_pulse, m_rid;
    int          m_drain;
    logic [31:0] m_pc;
    int          m_tkt;

    function automatic int age(input int t, input int h);
        return (t - h + DEPTH) % DEPTH;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_rob = 0; m_rat = 0; m_pulse = 0; m_rid = 0;
        m_drain = 0; m_pc = 0; m_tkt = 0;
    endtask

    task automatic model_step(input bit mf, input logic [31:0] a, input int t, input bit rid,
                              input int head, input bit robr, input bit ratr);
        bit take;
        m_pulse = 0;
        take = mf && (!m_busy || age(t, head) < age(m_tkt, head));
        if (take) begin
            m_pc = a; m_tkt = t; m_rid = rid; m_pulse = 1;
            m_rob = 1; m_rat = 1; m_busy = 1; m_drain = 0;
        end else if (m_busy && m_drain > 0) begin
            m_drain = m_drain - 1;
            if (m_drain == 0) m_busy = 0;
        end else if (m_busy) begin
            if (m_rob && robr) m_rob = 0;
            if (m_rat && ratr) m_rat = 0;
            if (!m_rob && !m_rat) begin
                if (DRAIN == 0) m_busy = 0;
                else m_drain = DRAIN;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("redirect_valid", 32'(fr.fetch_redirect_valid), 32'(m_pulse));
        chk("flush_frontend", 32'(fr.flush_frontend), 32'(m_pulse));
        chk("flush_backend", 32'(fr.flush_backend), 32'(m_pulse));
        chk("redirect_pc", fr.fetch_redirect_pc, m_pc);
        chk("flush_ticket", 32'(fr.flush_ticket), 32'(m_tkt));
        chk("rat_restore_id", 32'(fr.rat_restore_id), 32'(m_rid));
        chk("rob_rollback_valid", 32'(fr.rob_rollback_valid), 32'(m_rob));
        chk("rat_restore_valid", 32'(fr.rat_restore_valid), 32'(m_rat));
        chk("frontend_stall", 32'(fr.frontend_stall), 32'(m_busy));
        chk("busy", 32'(fr.busy), 32'(m_busy));
    endtask

    // Apply one cycle of inputs, advance the model, compare outputs of the next cycle.
    task automatic step(input bit mf, input logic [31:0] a, input int t, input bit rid,
                        input int head, input bit robr, input bit ratr);
        fr.must_flush         = mf;
        fr.correct_address    = a;
        fr.rob_ticket         = TW'(t);
        fr.rat_id             = rid;
        fr.rob_head           = TW'(head);
        fr.rob_rollback_ready = robr;
        fr.rat_restore_ready  = ratr;
        model_step(mf, a, t, rid, head, robr, ratr);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        fr.must_flush = 0; fr.correct_address = 0; fr.rob_ticket = 0; fr.rat_id = 0;
        fr.rob_head = 0; fr.rob_rollback_ready = 0; fr.rat_restore_ready = 0;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single flush with both readys high.
        step(1, 32'h0000_1040, 5, 1, 0, 1, 1);
        chk("t1_pulse", 32'(fr.fetch_redirect_valid), 32'd1);
        chk("t1_pc", fr.fetch_redirect_pc, 32'h0000_1040);
        chk("t1_ticket", 32'(fr.flush_ticket), 32'd5);
        step(0, 32'h0, 0, 0, 0, 1, 1);
        chk("t1_rob_valid_dropped", 32'(fr.rob_rollback_valid), 32'd0);
        idle(2);
        chk("t1_stall_released", 32'(fr.frontend_stall), 32'd0);
        // Flush in the first IDLE cycle after DRAIN is accepted.
        step(1, 32'h0000_5550, 2, 0, 0, 1, 1);
        chk("t1b_accept_after_drain", 32'(fr.fetch_redirect_valid), 32'd1);
        idle(4);

        // Staggered handshakes: ROB ready in T+2, RAT ready in T+4.
        step(1, 32'h0000_3000, 4, 0, 0, 0, 0);   // T
        step(0, 32'h0, 0, 0, 0, 0, 0);           // T+1
        step(0, 32'h0, 0, 0, 0, 1, 0);           // T+2
        chk("t2_rob_low_t3", 32'(fr.rob_rollback_valid), 32'd0);
        chk("t2_rat_high_t3", 32'(fr.rat_restore_valid), 32'd1);
        step(0, 32'h0, 0, 0, 0, 0, 0);           // T+3
        step(0, 32'h0, 0, 0, 0, 0, 1);           // T+4
        chk("t2_rat_low_t5", 32'(fr.rat_restore_valid), 32'd0);
        chk("t2_busy_t5", 32'(fr.busy), 32'd1);
        step(0, 32'h0, 0, 0, 0, 0, 0);           // T+5
        step(0, 32'h0, 0, 0, 0, 0, 0);           // T+6
        chk("t2_busy_low_t7", 32'(fr.busy), 32'd0);
        idle(2);

        // Older override, then a younger flush that must be ignored.
        step(1, 32'h0000_6000, 6, 0, 2, 0, 0);
        step(1, 32'h0000_2000, 3, 1, 2, 0, 0);
        chk("t3_override_pulse", 32'(fr.fetch_redirect_valid), 32'd1);
        chk("t3_override_pc", fr.fetch_redirect_pc, 32'h0000_2000);
        chk("t3_override_ticket", 32'(fr.flush_ticket), 32'd3);
        step(1, 32'h0000_7000, 7, 0, 2, 0, 0);
        chk("t4_younger_no_pulse", 32'(fr.fetch_redirect_valid), 32'd0);
        chk("t4_ticket_kept", 32'(fr.flush_ticket), 32'd3);
        chk("t4_pc_kept", fr.fetch_redirect_pc, 32'h0000_2000);
        idle(5);

        // Wrap-around age: head 6, latched 1 (age 3), new 7 (age 1) wins.
        step(1, 32'h0000_0100, 1, 0, 6, 0, 0);
        step(1, 32'h0000_0700, 7, 1, 6, 0, 0);
        chk("t5_wrap_pulse", 32'(fr.fetch_redirect_valid), 32'd1);
        chk("t5_wrap_ticket", 32'(fr.flush_ticket), 32'd7);

        // Asynchronous reset with both valids still high.
        step(0, 32'h0, 0, 0, 6, 0, 0);
        chk("t6_valid_before_reset", 32'(fr.rob_rollback_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 4) == 0, $urandom, int'($urandom_range(0, DEPTH - 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
